// File: rtl/heap_requester.sv
// heap_requester: one-request-at-a-time initiator for the level-triggered heap memory port.
// Build macro HEAP_ERROR_CHECK_EN: a nonzero heapError at capture is treated as a mismatch.
module heap_requester #(
    parameter int unsigned ADDRESS_BITS = 2,
    parameter int unsigned INDEX_BITS   = 1,
    parameter int unsigned DATA_BITS    = 12,
    parameter int unsigned SETTLE       = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    reqValid,
    output logic                    reqReady,
    input  logic [7:0]              reqAction,
    input  logic [ADDRESS_BITS-1:0] reqArray,
    input  logic [INDEX_BITS-1:0]   reqIndex,
    input  logic [DATA_BITS-1:0]    reqIn,
    input  logic [DATA_BITS-1:0]    reqExpected,
    input  logic                    reqCheck,
    output logic                    rspValid,
    input  logic                    rspReady,
    output logic [DATA_BITS-1:0]    rspData,
    output logic                    rspMatch,
    input  logic                    done,
    output logic                    finished,
    output logic                    success,
    output logic [15:0]             mismatches,
    output logic                    heapClock,
    output logic [7:0]              heapAction,
    output logic [ADDRESS_BITS-1:0] heapArray,
    output logic [INDEX_BITS-1:0]   heapIndex,
    output logic [DATA_BITS-1:0]    heapIn,
    input  logic [DATA_BITS-1:0]    heapOut,
    input  logic [31:0]             heapError
);

    localparam int unsigned CW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT,
        S_RESP,
        S_FINISH
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q;
    logic                    heap_clock_q;
    logic [7:0]              heap_action_q;
    logic [ADDRESS_BITS-1:0] heap_array_q;
    logic [INDEX_BITS-1:0]   heap_index_q;
    logic [DATA_BITS-1:0]    heap_in_q;
    logic [DATA_BITS-1:0]    expected_q;
    logic                    check_q;
    logic [DATA_BITS-1:0]    rsp_data_q;
    logic                    rsp_match_q;
    logic [15:0]             mismatches_q, mismatches_d;
    logic                    finished_q;
    logic                    success_q;

    logic accept;
    logic strobe;
    logic capture;
    logic finish_enter;
    logic data_miss;
    logic err_miss;
    logic miss;

    assign data_miss = check_q && (heapOut != expected_q);
`ifdef HEAP_ERROR_CHECK_EN
    assign err_miss = (heapError != '0);
`else
    logic unused_heap_error;
    assign unused_heap_error = ^heapError;
    assign err_miss          = 1'b0;
`endif
    assign miss = data_miss || err_miss;

    always_comb begin
        mismatches_d = mismatches_q;
        if (capture && miss && (mismatches_q != '1)) begin
            mismatches_d = mismatches_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (reqValid && !finished_q) begin
                    state_d = S_SETUP;
                end else if (done) begin
                    state_d = S_FINISH;
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_WAIT;
            S_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rspReady) begin
                    state_d = S_IDLE;
                end
            end
            S_FINISH: state_d = S_FINISH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept       = 1'b0;
        strobe       = 1'b0;
        capture      = 1'b0;
        finish_enter = 1'b0;
        reqReady     = 1'b0;
        rspValid     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                reqReady     = !finished_q && !reset;
                accept       = reqValid && !finished_q;
                finish_enter = !accept && done;
            end
            S_STROBE: strobe = 1'b1;
            S_WAIT:   capture = (cnt_q <= CW'(1));
            S_RESP:   rspValid = 1'b1;
            default: ;
        endcase
    end

    // heapAction clears together with heapClock on reset so any reset-induced edge is a no-op.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q         <= '0;
            heap_clock_q  <= 1'b0;
            heap_action_q <= '0;
            heap_array_q  <= '0;
            heap_index_q  <= '0;
            heap_in_q     <= '0;
            expected_q    <= '0;
            check_q       <= 1'b0;
            rsp_data_q    <= '0;
            rsp_match_q   <= 1'b0;
            mismatches_q  <= '0;
            finished_q    <= 1'b0;
            success_q     <= 1'b0;
        end else begin
            if (accept) begin
                heap_action_q <= reqAction;
                heap_array_q  <= reqArray;
                heap_index_q  <= reqIndex;
                heap_in_q     <= reqIn;
                expected_q    <= reqExpected;
                check_q       <= reqCheck;
            end
            if (strobe) begin
                heap_clock_q <= ~heap_clock_q;
                cnt_q        <= CW'(SETTLE);
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (capture) begin
                rsp_data_q  <= heapOut;
                rsp_match_q <= !miss;
            end
            mismatches_q <= mismatches_d;
            if (finish_enter) begin
                finished_q <= 1'b1;
                success_q  <= (mismatches_q == '0);
            end
        end
    end

    assign heapClock  = heap_clock_q;
    assign heapAction = heap_action_q;
    assign heapArray  = heap_array_q;
    assign heapIndex  = heap_index_q;
    assign heapIn     = heap_in_q;
    assign rspData    = rsp_data_q;
    assign rspMatch   = rsp_match_q;
    assign mismatches = mismatches_q;
    assign finished   = finished_q;
    assign success    = success_q;

endmodule

// File: tb/tb_heap_requester.sv
// Self-checking bench for heap_requester: directed steps plus randomized requests against a
// small heap memory stub and a behavioural expectation model.
module tb_heap_requester;

    logic        clock;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [7:0]  reqAction;
    logic [1:0]  reqArray;
    logic [0:0]  reqIndex;
    logic [11:0] reqIn;
    logic [11:0] reqExpected;
    logic        reqCheck;
    logic        rspValid;
    logic        rspReady;
    logic [11:0] rspData;
    logic        rspMatch;
    logic        done;
    logic        finished;
    logic        success;
    logic [15:0] mismatches;
    logic        heapClock;
    logic [7:0]  heapAction;
    logic [1:0]  heapArray;
    logic [0:0]  heapIndex;
    logic [11:0] heapIn;
    logic [11:0] heapOut;
    logic [31:0] heapError;

    int errors = 0;
    int checks = 0;
    int mm     = 0;

    int unsigned sizes [4];
    int unsigned mem   [4][2];

    heap_requester #(
        .ADDRESS_BITS(2),
        .INDEX_BITS  (1),
        .DATA_BITS   (12),
        .SETTLE      (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqAction  (reqAction),
        .reqArray   (reqArray),
        .reqIndex   (reqIndex),
        .reqIn      (reqIn),
        .reqExpected(reqExpected),
        .reqCheck   (reqCheck),
        .rspValid   (rspValid),
        .rspReady   (rspReady),
        .rspData    (rspData),
        .rspMatch   (rspMatch),
        .done       (done),
        .finished   (finished),
        .success    (success),
        .mismatches (mismatches),
        .heapClock  (heapClock),
        .heapAction (heapAction),
        .heapArray  (heapArray),
        .heapIndex  (heapIndex),
        .heapIn     (heapIn),
        .heapOut    (heapOut),
        .heapError  (heapError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Size returns the array length; Greater counts stored elements strictly above the operand.
    function automatic logic [11:0] ref_result(input logic [7:0] a, input logic [1:0] ar,
                                               input logic [11:0] din);
        int unsigned n;
        n = 0;
        if (a == 8'd4) return 12'(sizes[ar]);
        for (int unsigned i = 0; i < sizes[ar]; i++) begin
            if (mem[ar][i] > 32'(din)) n++;
        end
        return 12'(n);
    endfunction

    // Memory stub: acts on every heapClock transition, code 0 (and unknown codes) do nothing.
    always @(heapClock) begin
        #1;
        if (heapAction == 8'd4 || heapAction == 8'd9) begin
            heapOut = ref_result(heapAction, heapArray, heapIn);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        reqValid = 1'b0;
        rspReady = 1'b0;
        done     = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_reqReady", 32'(reqReady), 0);
        check("rst_rspValid", 32'(rspValid), 0);
        check("rst_finished", 32'({finished, success}), 0);
        check("rst_mismatches", 32'(mismatches), 0);
        check("rst_heapClock", 32'(heapClock), 0);
        check("rst_heapAction", 32'(heapAction), 0);
        reset = 1'b0;
        mm    = 0;
        @(negedge clock);
    endtask

    task automatic do_req(input logic [7:0] a, input logic [1:0] ar, input logic ix,
                          input logic [11:0] din, input logic [11:0] ev, input logic ck,
                          input int hold);
        logic        hc0;
        logic        hc1;
        logic [11:0] want;
        logic        m;
        check("idle_reqReady", 32'(reqReady), 1);
        hc0         = heapClock;
        hc1         = ~hc0;
        reqValid    = 1'b1;
        reqAction   = a;
        reqArray    = ar;
        reqIndex    = ix;
        reqIn       = din;
        reqExpected = ev;
        reqCheck    = ck;
        rspReady    = 1'b0;
        @(negedge clock);
        reqValid = 1'b0;
        check("setup_action", 32'(heapAction), 32'(a));
        check("setup_addr", 32'({heapArray, heapIndex}), 32'({ar, ix}));
        check("setup_in", 32'(heapIn), 32'(din));
        check("busy_reqReady", 32'(reqReady), 0);
        check("setup_clk", 32'(heapClock), 32'(hc0));
        @(negedge clock);
        check("strobe_clk", 32'(heapClock), 32'(hc0));
        @(negedge clock);
        check("toggle_clk", 32'(heapClock), 32'(hc1));
        check("wait_rspValid", 32'(rspValid), 0);
        @(negedge clock);
        want = ref_result(a, ar, din);
        m    = !ck || (want == ev);
`ifdef HEAP_ERROR_CHECK_EN
        if (heapError != 0) m = 1'b0;
`endif
        if (!m && mm < 65535) mm++;
        check("rsp_valid", 32'(rspValid), 1);
        check("rsp_data", 32'(rspData), 32'(want));
        check("rsp_match", 32'(rspMatch), 32'(m));
        check("rsp_mismatches", 32'(mismatches), 32'(mm));
        check("rsp_finished", 32'(finished), 0);
        for (int i = 0; i < hold; i++) begin
            reqValid  = 1'b1;
            reqAction = a ^ 8'h0D;
            @(negedge clock);
            check("hold_rspValid", 32'(rspValid), 1);
            check("hold_data", 32'({rspData, rspMatch}), 32'({want, m}));
            check("hold_reqReady", 32'(reqReady), 0);
        end
        rspReady = 1'b1;
        @(negedge clock);
        rspReady  = 1'b0;
        reqValid  = 1'b0;
        reqAction = a;
        check("ret_rspValid", 32'(rspValid), 0);
        check("ret_reqReady", 32'(reqReady), 1);
        check("ret_action_kept", 32'(heapAction), 32'(a));
        check("ret_clk_level", 32'(heapClock), 32'(hc1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ra;
        logic [1:0]  rar;
        logic        rix;
        logic [11:0] rdin;
        logic [11:0] rwant;
        logic [11:0] rexp;
        logic        rck;

        sizes[0] = 2; mem[0][0] = 5;  mem[0][1] = 9;
        sizes[1] = 2; mem[1][0] = 3;  mem[1][1] = 7;
        sizes[2] = 1; mem[2][0] = 11; mem[2][1] = 0;
        sizes[3] = 0; mem[3][0] = 0;  mem[3][1] = 0;
        reqAction   = '0;
        reqArray    = '0;
        reqIndex    = '0;
        reqIn       = '0;
        reqExpected = '0;
        reqCheck    = 1'b0;
        heapOut     = '0;
        heapError   = '0;
        do_reset();

        do_req(8'd4, 2'd1, 1'b0, 12'd0, 12'd2, 1'b1, 0);
        do_req(8'd9, 2'd0, 1'b0, 12'd6, 12'd1, 1'b1, 0);
        do_req(8'd9, 2'd0, 1'b0, 12'd6, 12'd2, 1'b1, 0);
        check("one_mismatch", 32'(mismatches), 1);
        do_req(8'd4, 2'd2, 1'b1, 12'd0, 12'd1, 1'b1, 3);

        done = 1'b1;
        do_req(8'd9, 2'd1, 1'b0, 12'd4, 12'd0, 1'b0, 0);
        @(negedge clock);
        check("fin_after_mismatch", 32'({finished, success}), 32'(2'b10));
        check("fin_reqReady", 32'(reqReady), 0);
        reqValid = 1'b1;
        repeat (3) @(negedge clock);
        check("fin_ignores_req", 32'({rspValid, heapAction}), 32'({1'b0, 8'd9}));
        check("fin_terminal", 32'(finished), 1);
        do_reset();

        for (int n = 0; n < 40; n++) begin
            ra    = ($urandom_range(0, 1) == 0) ? 8'd4 : 8'd9;
            rar   = 2'($urandom_range(0, 3));
            rix   = 1'($urandom_range(0, 1));
            rdin  = 12'($urandom_range(0, 13));
            rwant = ref_result(ra, rar, rdin);
            rck   = 1'($urandom_range(0, 1));
            rexp  = ($urandom_range(0, 1) == 0) ? rwant : rwant ^ 12'(1 << $urandom_range(0, 11));
            do_req(ra, rar, rix, rdin, rexp, rck, $urandom_range(0, 2));
        end

        do_req(8'd4, 2'd1, 1'b0, 12'd0, 12'd7, 1'b1, 0);
        check("pre_reset_mm", 32'(mismatches != 0), 1);
        reqValid = 1'b1;
        reqAction = 8'd9; reqArray = 2'd0; reqIn = 12'd1; reqCheck = 1'b1; reqExpected = 12'd0;
        @(negedge clock);
        reqValid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rstwait_clk", 32'(heapClock), 0);
        check("rstwait_action", 32'(heapAction), 0);
        check("rstwait_rspValid", 32'(rspValid), 0);
        check("rstwait_mm", 32'(mismatches), 0);
        reset = 1'b0;
        mm    = 0;
        @(negedge clock);
        check("rstwait_ready", 32'(reqReady), 1);
        repeat (3) @(negedge clock);
        check("rstwait_no_rsp", 32'(rspValid), 0);

        heapError = 32'd1;
        do_req(8'd4, 2'd0, 1'b0, 12'd0, 12'd0, 1'b0, 0);
        heapError = 32'd0;
        do_reset();

        do_req(8'd9, 2'd1, 1'b1, 12'd2, 12'd2, 1'b1, 1);
        done = 1'b1;
        @(negedge clock);
        check("fin_success", 32'({finished, success}), 32'(2'b11));
        check("fin_ready_low", 32'(reqReady), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/heap_requester.md
Name: heap_requester

Overview:
Initiator side of the heap memory port. It accepts one request at a time on a valid/ready handshake and drives the level-triggered memory port (action/array/index/in, plus a toggled heapClock). It captures heapOut, compares it against an expected value and returns a response. It counts mismatches and raises finished/success when the upstream test program signals done. It sits between the test-program sequencer and the Memory instance in the fpga top level.

Parameters:
ADDRESS_BITS, 2, width of the array number
INDEX_BITS, 1, width of the index within an array
DATA_BITS, 12, width of data in/out
SETTLE, 1, clock cycles (≥1) between a heapClock toggle and capture of heapOut

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
reqValid  in  1  request present
reqReady  out  1  requester can accept a request
reqAction  in  8  operation code (4 = Size, 9 = Greater)
reqArray  in  ADDRESS_BITS  target array
reqIndex  in  INDEX_BITS  index within the array
reqIn  in  DATA_BITS  input operand
reqExpected  in  DATA_BITS  expected heapOut
reqCheck  in  1  1 = compare the result against reqExpected
rspValid  out  1  response present
rspReady  in  1  consumer accepts the response
rspData  out  DATA_BITS  captured heapOut
rspMatch  out  1  result matched, or was not checked
done  in  1  program complete
finished  out  1  high once done has been honoured
success  out  1  high with finished if mismatches == 0
mismatches  out  16  saturating mismatch count
heapClock  out  1  memory strobe; memory acts on each transition
heapAction  out  8  registered action
heapArray  out  ADDRESS_BITS  registered array
heapIndex  out  INDEX_BITS  registered index
heapIn  out  DATA_BITS  registered data
heapOut  in  DATA_BITS  memory result
heapError  in  32  memory error word

Behaviour:
- Reset (synchronous): state=IDLE. All outputs are 0, including heapClock, heapAction (0 is a no-op code), finished, success, mismatches and rspValid. reqReady reads 0 while reset is high.
- reqReady = (state==IDLE) && !finished.
- IDLE:
  - reqValid && reqReady: latch reqAction/reqArray/reqIndex/reqIn into the heap* registers; latch reqExpected and reqCheck; go to SETUP.
  - Else if done: go to FINISH.
  - reqValid has priority over done in the same cycle; done must stay high until it is honoured.
- SETUP: one cycle so the memory inputs are stable before the strobe; go to STROBE.
- STROBE: heapClock <= ~heapClock (exactly one toggle per request); load wait counter with SETTLE; go to WAIT.
- WAIT: decrement the counter. When it reaches 0:
  - rspData <= heapOut.
  - rspMatch <= !reqCheck || (heapOut == expected).
  - On a mismatch, increment mismatches, saturating at 0xFFFF.
  - Go to RESP.
- RESP: rspValid=1; rspData and rspMatch are held stable. On rspReady, rspValid clears and the block returns to IDLE.
- FINISH: finished=1 and success=(mismatches==0), both registered on entry. The block is terminal: only reset leaves it, and reqValid is ignored.
- Latency with SETTLE=1:
  - request accepted at cycle T; heapClock toggles at the end of T+2; rspValid is high from T+4.
  - With rspReady held high the minimum period is 5 cycles per request.
- heapClock keeps its level between requests; it is never toggled outside STROBE.
- Equality compare is the full DATA_BITS width, unsigned.
- Reset mid-operation abandons the request, including in WAIT or RESP:
  - no response is issued and mismatches clears.
  - heapClock may return to 0 (a transition), but heapAction=0 is applied at the same edge, so the memory performs no operation.

Optional Feature:
HEAP_ERROR_CHECK_EN.
- Defined: at capture, heapError != 0 forces rspMatch=0 and increments mismatches, regardless of reqCheck.
- Undefined: heapError is ignored and rspMatch depends only on reqCheck/reqExpected.
- Ports are identical in both builds.

Test Plan:
1. Model with arraySizes[1]=2. Request action=4, array=1, check=1, expected=2, accepted at T → heapClock toggles once; rspValid at T+4; rspData=2; rspMatch=1; mismatches=0.
2. Array 0 holds {5,9}, size 2. Greater with in=6, expected=1 → rspMatch=1. Repeat with expected=2 → rspMatch=0, mismatches=1.
3. Hold rspReady low 3 cycles in RESP → rspValid, rspData and rspMatch stable; reqReady=0; a pending reqValid is not accepted until the cycle after rspReady.
4. No mismatches, then done=1 in IDLE → finished=1, success=1 next cycle. After one mismatch → finished=1, success=0. done and reqValid in the same cycle → request accepted, finished stays 0.
5. Assert reset during WAIT → next cycle heapClock=0, heapAction=0, rspValid=0, mismatches=0; reqReady=1 the cycle after release; no response emitted.
6. heapError=1, reqCheck=0 → rspMatch=0 and mismatches+1 with HEAP_ERROR_CHECK_EN defined; rspMatch=1 and no count without it.
